axi_llc_sram_req_if: RTL and testbench

Initiator-side front end for the LLC SRAM macro wrapper, sitting between the tag/data pipeline and the SRAM port. It accepts a valid/ready command stream, drives the SRAM req/gnt port, and tracks in-flight reads across the fixed SRAM read latency. Read data is captured into a response FIFO with valid/ready backpressure. Credit-based read admission guarantees the FIFO never overflows, even though the SRAM itself cannot be stalled.

---
 rtl/axi_llc_sram_req_if.sv | 138 +++++++++++++
 tb/tb_axi_llc_sram_req_if.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_llc_sram_req_if.sv
// axi_llc_sram_req_if: initiator-side front end for the LLC SRAM macro wrapper.
// Passes a valid/ready command stream onto the SRAM req/gnt port. It tracks reads
// in flight across the fixed SRAM read latency and captures their data into a
// response FIFO. Read admission is credit-based, so the FIFO can never overflow,
// even though the SRAM itself cannot be stalled.
// Optional feature macro: AXI_LLC_SRAM_REQ_IF_BYPASS_EN. When it is defined,
// captured data is presented the same cycle it arrives if the FIFO is empty.
module axi_llc_sram_req_if #(
  parameter int NumWords  = 1024,
  parameter int DataWidth = 128,
  parameter int ByteWidth = 8,
  parameter int Latency   = 1,
  parameter int RespDepth = 2,
  localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int CntWidth  = $clog2(RespDepth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic                 sram_gnt_i,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic [CntWidth-1:0]  outstanding_o
);

  localparam int PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;

  logic [Latency-1:0]   r_track;
  logic [DataWidth-1:0] r_mem [RespDepth];
  logic [PtrWidth-1:0]  r_wptr;
  logic [PtrWidth-1:0]  r_rptr;
  logic [CntWidth-1:0]  r_count;
  logic [CntWidth-1:0]  r_outstanding;

  logic w_can_issue;
  logic w_hs;
  logic w_rd_hs;
  logic w_cap;
  logic w_empty;
  logic w_full;
  logic w_byp;
  logic w_fire;
  logic w_fifo_pop;
  logic w_push;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(RespDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Admission: writes always go; a read needs a free response slot. Reset blocks both.
  assign w_can_issue = req_we_i | (r_outstanding != CntWidth'(RespDepth));
  assign sram_req_o  = req_valid_i & w_can_issue & ~rst_i;
  assign req_ready_o = sram_gnt_i & w_can_issue & ~rst_i;
  assign w_hs        = sram_req_o & sram_gnt_i;
  assign w_rd_hs     = w_hs & ~req_we_i;

  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  assign w_cap   = r_track[Latency-1];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CntWidth'(RespDepth));

`ifdef AXI_LLC_SRAM_REQ_IF_BYPASS_EN
  assign w_byp        = w_cap & w_empty;
  assign resp_valid_o = ~w_empty | w_cap;
  assign resp_rdata_o = w_empty ? sram_rdata_i : r_mem[r_rptr];
`else
  assign w_byp        = 1'b0;
  assign resp_valid_o = ~w_empty;
  assign resp_rdata_o = r_mem[r_rptr];
`endif

  assign w_fire        = resp_valid_o & resp_ready_i;
  assign w_fifo_pop    = w_fire & ~w_empty;
  assign w_push        = w_cap & ~(w_byp & resp_ready_i);
  assign outstanding_o = r_outstanding;

  // Read tracking: a 1 walks Latency stages, marking the cycle its data is valid
  always_ff @(posedge clk_i) begin
    if (rst_i) r_track <= '0;
    else       r_track <= (r_track << 1) | Latency'(w_rd_hs);
  end

  // Response FIFO control and the outstanding-read credit counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_push)     r_wptr <= ptr_inc(r_wptr);
      if (w_fifo_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_fifo_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case ({w_rd_hs, w_fire})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // FIFO storage: data only, never reset
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= sram_rdata_i;
  end

`ifndef SYNTHESIS
  // Credit accounting must make a push into a full FIFO without a pop unreachable
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(w_push && w_full && !w_fifo_pop))
        else $error("axi_llc_sram_req_if: response FIFO overflow");
    end
  end
`endif

endmodule

// File: tb/tb_axi_llc_sram_req_if.sv
// Testbench for axi_llc_sram_req_if: scenario tasks checked against a queue-based
// reference model of credits, in-flight reads and the response FIFO.
// Covers both builds of AXI_LLC_SRAM_REQ_IF_BYPASS_EN.
module tb_axi_llc_sram_req_if;

  localparam int NW    = 64;
  localparam int DW    = 16;
  localparam int BYW   = 8;
  localparam int LAT   = 1;
  localparam int DEPTH = 2;
  localparam int AW    = 6;
  localparam int BEW   = 2;
  localparam int CW    = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [BEW-1:0] req_be_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [DW-1:0] resp_rdata_o;
  logic          sram_req_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [BEW-1:0] sram_be_o;
  logic          sram_gnt_i;
  logic [DW-1:0] sram_rdata_i;
  logic [CW-1:0] outstanding_o;

  axi_llc_sram_req_if #(
    .NumWords(NW), .DataWidth(DW), .ByteWidth(BYW), .Latency(LAT), .RespDepth(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_gnt_i(sram_gnt_i),
    .sram_rdata_i(sram_rdata_i), .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: SRAM contents, reads in flight, response FIFO contents
  logic [DW-1:0] smem [NW];
  int            pend_due[$];
  logic [DW-1:0] pend_data[$];
  logic [DW-1:0] fifo_q[$];
  int            cyc;

  bit            exp_sreq, exp_rdy, exp_rv, exp_cap;
  logic [DW-1:0] exp_rd;
  int            exp_out;

  int n_checks = 0;
  int n_errs   = 0;

  // Drive SRAM read data and derive this cycle's expected outputs from the model
  task automatic eval();
    bit ok;
    exp_cap = (pend_due.size() > 0) && (pend_due[0] == cyc);
    sram_rdata_i = exp_cap ? pend_data[0] : DW'($urandom);
    exp_out  = pend_due.size() + fifo_q.size();
    ok       = req_we_i || (exp_out < DEPTH);
    exp_sreq = !rst_i && req_valid_i && ok;
    exp_rdy  = !rst_i && sram_gnt_i && ok;
    exp_rv   = fifo_q.size() > 0;
    exp_rd   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
`ifdef AXI_LLC_SRAM_REQ_IF_BYPASS_EN
    if (fifo_q.size() == 0 && exp_cap) begin
      exp_rv = 1'b1;
      exp_rd = pend_data[0];
    end
`endif
    #1;
  endtask

  // Advance one clock and apply that edge's events to the model
  task automatic tick();
    bit hs, fire, byp_take, cap;
    logic [DW-1:0] d;
    hs   = exp_sreq && sram_gnt_i;
    fire = exp_rv && resp_ready_i;
    cap  = exp_cap;
    @(posedge clk_i);
    if (rst_i) begin
      pend_due.delete();
      pend_data.delete();
      fifo_q.delete();
    end else begin
      byp_take = fire && (fifo_q.size() == 0);
      if (fire && !byp_take) void'(fifo_q.pop_front());
      if (cap) begin
        d = pend_data.pop_front();
        void'(pend_due.pop_front());
        if (!byp_take) fifo_q.push_back(d);
      end
      if (hs) begin
        if (req_we_i) begin
          for (int b = 0; b < BEW; b++)
            if (req_be_i[b]) smem[req_addr_i][b*BYW +: BYW] = req_wdata_i[b*BYW +: BYW];
        end else begin
          pend_due.push_back(cyc + LAT);
          pend_data.push_back(smem[req_addr_i]);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    sram_gnt_i   = 1'b1;
    repeat (LAT + DEPTH + 3) begin
      eval();
      tick();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 6'd3; sram_gnt_i = 1'b1;
    resp_ready_i = 1'b1;
    eval(); tick();
    eval(); tick();
    eval();
    n_checks++;
    if (sram_req_o !== 1'b0) begin n_errs++; $display("FAIL reset_sram_req got=%0b exp=0", sram_req_o); end
    n_checks++;
    if (req_ready_o !== 1'b0) begin n_errs++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready_o); end
    n_checks++;
    if (resp_valid_o !== 1'b0) begin n_errs++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid_o); end
    n_checks++;
    if (outstanding_o !== CW'(0)) begin n_errs++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o); end
    tick();
    rst_i = 1'b0;
    req_valid_i = 1'b0;
    eval(); tick();
  endtask

  task automatic test_single_read();
    drain();
    smem[5] = 16'h00A5;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 6'd5;
    sram_gnt_i = 1'b1; resp_ready_i = 1'b1;
    eval();
    n_checks++;
    if (sram_req_o !== 1'b1 || req_ready_o !== 1'b1) begin
      n_errs++; $display("FAIL single_issue got req=%0b rdy=%0b exp=1,1", sram_req_o, req_ready_o);
    end
    tick();
    req_valid_i = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      eval();
      n_checks++;
      if (outstanding_o !== CW'(exp_out)) begin
        n_errs++; $display("FAIL single_outstanding k=%0d got=%0d exp=%0d", k, outstanding_o, exp_out);
      end
      n_checks++;
      if (resp_valid_o !== exp_rv) begin
        n_errs++; $display("FAIL single_resp_valid k=%0d got=%0b exp=%0b", k, resp_valid_o, exp_rv);
      end
      if (exp_rv) begin
        n_checks++;
        if (resp_rdata_o !== 16'h00A5) begin
          n_errs++; $display("FAIL single_rdata got=%h exp=00a5", resp_rdata_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int k;
    drain();
    k = 0;
    resp_ready_i = 1'b0;
    sram_gnt_i   = 1'b1;
    req_we_i     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      resp_ready_i = (c >= 6);
      req_valid_i  = (k < 4);
      req_addr_i   = AW'(10 + k);
      eval();
      n_checks++;
      if (req_ready_o !== exp_rdy || sram_req_o !== exp_sreq) begin
        n_errs++; $display("FAIL b2b_issue c=%0d got rdy=%0b req=%0b exp rdy=%0b req=%0b",
                           c, req_ready_o, sram_req_o, exp_rdy, exp_sreq);
      end
      n_checks++;
      if (outstanding_o !== CW'(exp_out)) begin
        n_errs++; $display("FAIL b2b_outstanding c=%0d got=%0d exp=%0d", c, outstanding_o, exp_out);
      end
      if (c == 5) begin
        n_checks++;
        if (outstanding_o !== CW'(DEPTH) || req_ready_o !== 1'b0) begin
          n_errs++; $display("FAIL b2b_saturate got out=%0d rdy=%0b exp out=%0d rdy=0",
                             outstanding_o, req_ready_o, DEPTH);
        end
      end
      n_checks++;
      if (resp_valid_o !== exp_rv || (exp_rv && resp_rdata_o !== exp_rd)) begin
        n_errs++; $display("FAIL b2b_resp c=%0d got v=%0b d=%h exp v=%0b d=%h",
                           c, resp_valid_o, resp_rdata_o, exp_rv, exp_rd);
      end
      if (req_valid_i && exp_rdy) k++;
      tick();
    end
    n_checks++;
    if (k != 4) begin n_errs++; $display("FAIL b2b_accepted got=%0d exp=4", k); end
  endtask

  task automatic test_write_stall();
    logic [DW-1:0] wd;
    drain();
    wd = DW'($urandom);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 6'd33; req_wdata_i = wd; req_be_i = 2'b11;
    for (int c = 0; c < 4; c++) begin
      sram_gnt_i = (c == 3);
      eval();
      n_checks++;
      if (sram_req_o !== 1'b1 || sram_we_o !== 1'b1 || sram_addr_o !== 6'd33 ||
          sram_wdata_o !== wd || sram_be_o !== 2'b11) begin
        n_errs++; $display("FAIL wstall_port c=%0d got req=%0b we=%0b a=%0d d=%h be=%b exp 1,1,33,%h,11",
                           c, sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o, wd);
      end
      n_checks++;
      if (req_ready_o !== (c == 3)) begin
        n_errs++; $display("FAIL wstall_ready c=%0d got=%0b exp=%0b", c, req_ready_o, (c == 3));
      end
      tick();
    end
    req_valid_i = 1'b0;
    eval();
    n_checks++;
    if (outstanding_o !== CW'(0)) begin n_errs++; $display("FAIL wstall_outstanding got=%0d exp=0", outstanding_o); end
    tick();
  endtask

  task automatic test_full_pop_issue();
    int k;
    drain();
    resp_ready_i = 1'b0; req_we_i = 1'b0; sram_gnt_i = 1'b1;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      resp_ready_i = (c >= LAT + 3);
      req_valid_i  = (k < 3);
      req_addr_i   = AW'(20 + k);
      eval();
      if (c == LAT + 3) begin
        n_checks++;
        if (outstanding_o !== CW'(DEPTH)) begin
          n_errs++; $display("FAIL full_outstanding got=%0d exp=%0d", outstanding_o, DEPTH);
        end
      end
      n_checks++;
      if (req_ready_o !== exp_rdy || outstanding_o !== CW'(exp_out)) begin
        n_errs++; $display("FAIL full_ctrl c=%0d got rdy=%0b out=%0d exp rdy=%0b out=%0d",
                           c, req_ready_o, outstanding_o, exp_rdy, exp_out);
      end
      n_checks++;
      if (resp_valid_o !== exp_rv || (exp_rv && resp_rdata_o !== exp_rd)) begin
        n_errs++; $display("FAIL full_resp c=%0d got v=%0b d=%h exp v=%0b d=%h",
                           c, resp_valid_o, resp_rdata_o, exp_rv, exp_rd);
      end
      if (req_valid_i && exp_rdy) k++;
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    drain();
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 6'd7; sram_gnt_i = 1'b1; resp_ready_i = 1'b0;
    eval(); tick();
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    eval(); tick();
    rst_i = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      eval();
      n_checks++;
      if (resp_valid_o !== 1'b0 || outstanding_o !== CW'(0)) begin
        n_errs++; $display("FAIL rstfl c=%0d got v=%0b out=%0d exp v=0 out=0", c, resp_valid_o, outstanding_o);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit hold;
    hold = 1'b0;
    drain();
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        req_valid_i = ($urandom_range(0, 3) != 0);
        req_we_i    = ($urandom_range(0, 2) == 0);
        req_addr_i  = AW'($urandom);
        req_wdata_i = DW'($urandom);
        req_be_i    = BEW'($urandom);
      end
      sram_gnt_i   = ($urandom_range(0, 4) != 0);
      resp_ready_i = ($urandom_range(0, 2) != 0);
      eval();
      n_checks++;
      if (sram_req_o !== exp_sreq || req_ready_o !== exp_rdy) begin
        n_errs++; $display("FAIL rnd_issue c=%0d got req=%0b rdy=%0b exp req=%0b rdy=%0b",
                           c, sram_req_o, req_ready_o, exp_sreq, exp_rdy);
      end
      n_checks++;
      if (outstanding_o !== CW'(exp_out)) begin
        n_errs++; $display("FAIL rnd_outstanding c=%0d got=%0d exp=%0d", c, outstanding_o, exp_out);
      end
      n_checks++;
      if (resp_valid_o !== exp_rv || (exp_rv && resp_rdata_o !== exp_rd)) begin
        n_errs++; $display("FAIL rnd_resp c=%0d got v=%0b d=%h exp v=%0b d=%h",
                           c, resp_valid_o, resp_rdata_o, exp_rv, exp_rd);
      end
      hold = req_valid_i && !exp_rdy;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) smem[i] = DW'($urandom);
    cyc = 0;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_be_i = '0;
    resp_ready_i = 1'b0; sram_gnt_i = 1'b0; sram_rdata_i = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_stall();
    test_full_pop_issue();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
